// File: rtl/bg_index_fetch.sv
// bg_index_fetch: two-stage background index fetch with frame-synchronous horizontal scroll (scroll enabled by BG_SCROLL_EN)
module bg_index_fetch (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [9:0]  draw_x,
  input  logic [9:0]  draw_y,
  input  logic        active_in,
  input  logic        hs_in,
  input  logic        vs_in,
  output logic [16:0] rom_addr,
  input  logic [3:0]  rom_data,
  input  logic [8:0]  scroll_x_in,
  input  logic        scroll_load,
  output logic        scroll_ack,
  output logic [3:0]  index_out,
  output logic        active_out,
  output logic        hs_out,
  output logic        vs_out
);
  logic [16:0] addr_q, addr_d;
  logic [3:0]  idx_q;
  logic [1:0]  act_q, hs_q, vs_q;
  logic [8:0]  scroll_cur;
  logic [9:0]  xsum;
  logic [8:0]  xs;
  logic        unused_lsb;

  assign unused_lsb = draw_x[0] ^ draw_y[0];

  // map the pixel onto the half-resolution image, wrapping the column by the scroll offset
  always_comb begin
    xsum   = {1'b0, draw_x[9:1]} + {1'b0, scroll_cur};
    xs     = (xsum >= 10'd320) ? 9'(xsum - 10'd320) : xsum[8:0];
    addr_d = active_in ? ({8'd0, draw_y[9:1]} * 17'd320 + {8'd0, xs}) : 17'd0;
  end

  // address stage, then ROM capture aligned with the two-deep control pipeline
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      addr_q <= 17'd0;
      idx_q  <= 4'd0;
      act_q  <= 2'b00;
      hs_q   <= 2'b11;
      vs_q   <= 2'b11;
    end else begin
      addr_q <= addr_d;
      idx_q  <= act_q[0] ? rom_data : 4'd0;
      act_q  <= {act_q[0], active_in};
      hs_q   <= {hs_q[0], hs_in};
      vs_q   <= {vs_q[0], vs_in};
    end

  assign rom_addr   = addr_q;
  assign index_out  = idx_q;
  assign active_out = act_q[1];
  assign hs_out     = hs_q[1];
  assign vs_out     = vs_q[1];

`ifdef BG_SCROLL_EN
  typedef enum logic {IDLE, PENDING} state_t;
  state_t     state_q, state_d;
  logic [8:0] cur_q, cur_d, pend_q, pend_d, load_val;
  logic       vs_hist_q, ack_q, ack_d, frame_start;

  assign frame_start = vs_hist_q & ~vs_in;
  assign load_val    = (scroll_x_in >= 9'd320) ? scroll_x_in - 9'd320 : scroll_x_in;

  // buffer the requested offset and only commit it at a frame start; a same-cycle load re-arms
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    pend_d  = pend_q;
    ack_d   = 1'b0;
    if (state_q == PENDING && frame_start) begin
      cur_d   = pend_q;
      ack_d   = 1'b1;
      state_d = IDLE;
    end
    if (scroll_load) begin
      pend_d  = load_val;
      state_d = PENDING;
    end
  end

  // scroll state; reset drops any pending offset without acknowledging it
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q   <= IDLE;
      cur_q     <= 9'd0;
      pend_q    <= 9'd0;
      vs_hist_q <= 1'b1;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      pend_q    <= pend_d;
      vs_hist_q <= vs_in;
      ack_q     <= ack_d;
    end

  assign scroll_cur = cur_q;
  assign scroll_ack = ack_q;
`else
  logic unused_scroll;
  assign unused_scroll = ^{scroll_x_in, scroll_load};
  assign scroll_cur    = 9'd0;
  assign scroll_ack    = 1'b0;
`endif
endmodule

// File: tb/tb_bg_index_fetch.sv
// tb_bg_index_fetch: table vectors plus scroll sequences, checked through an address/output scoreboard
module tb_bg_index_fetch;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [9:0]  draw_x = '0, draw_y = '0;
  logic        active_in = 1'b0, hs_in = 1'b1, vs_in = 1'b1;
  logic [16:0] rom_addr;
  logic [3:0]  rom_data;
  logic [8:0]  scroll_x_in = '0;
  logic        scroll_load = 1'b0;
  logic        scroll_ack;
  logic [3:0]  index_out;
  logic        active_out, hs_out, vs_out;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [9:0]  dx, dy;
    logic        act, hs, vs;
    logic [16:0] ea;
  } vec_t;

  typedef struct {
    logic [16:0] addr;
    logic [3:0]  idx;
    logic        act, hs, vs, ack;
  } exp_t;

  exp_t addr_q[$];
  exp_t out_q[$];
  vec_t tbl[10];

  logic [8:0] m_cur = '0, m_pend = '0;
  logic       m_pend_v = 1'b0, m_vs = 1'b1;

  bg_index_fetch dut (
    .clk(clk), .reset_n(reset_n), .draw_x(draw_x), .draw_y(draw_y),
    .active_in(active_in), .hs_in(hs_in), .vs_in(vs_in),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .scroll_x_in(scroll_x_in), .scroll_load(scroll_load), .scroll_ack(scroll_ack),
    .index_out(index_out), .active_out(active_out), .hs_out(hs_out), .vs_out(vs_out)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] rom_f(input logic [16:0] a);
    return (a == 17'd965) ? 4'h7 : (a[3:0] ^ a[7:4] ^ 4'h9);
  endfunction

  // the ROM word for the address registered last edge is visible throughout this cycle
  assign rom_data = rom_f(rom_addr);

  function automatic logic [16:0] addr_of(input logic [9:0] dx, input logic [9:0] dy);
    int s;
    s = int'(dx >> 1) + int'(m_cur);
    if (s >= 320) s -= 320;
    return 17'(int'(dy >> 1) * 320 + s);
  endfunction

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
    end
  endtask

  task automatic cycle();
    exp_t e;
    @(posedge clk);
    #1;
    if (out_q.size() > 0) begin
      e = out_q.pop_front();
      chk("index_out", 32'(index_out), 32'(e.idx));
      chk("active_out", 32'(active_out), 32'(e.act));
      chk("hs_out", 32'(hs_out), 32'(e.hs));
      chk("vs_out", 32'(vs_out), 32'(e.vs));
    end
    if (addr_q.size() > 0) begin
      e = addr_q.pop_front();
      chk("rom_addr", 32'(rom_addr), 32'(e.addr));
      chk("scroll_ack", 32'(scroll_ack), 32'(e.ack));
      out_q.push_back(e);
    end
  endtask

  task automatic apply(input logic [9:0] dx, input logic [9:0] dy, input logic act, input logic hs,
                       input logic vs, input logic ld, input logic [8:0] sx, input logic [16:0] ea);
    exp_t e;
    draw_x = dx; draw_y = dy; active_in = act; hs_in = hs; vs_in = vs;
    scroll_load = ld; scroll_x_in = sx;
    e.addr = act ? ea : 17'd0;
    e.idx  = act ? rom_f(e.addr) : 4'd0;
    e.act  = act; e.hs = hs; e.vs = vs; e.ack = 1'b0;
`ifdef BG_SCROLL_EN
    if (m_pend_v && m_vs && !vs) begin
      m_cur = m_pend; e.ack = 1'b1; m_pend_v = 1'b0;
    end
    if (ld) begin
      m_pend = (sx >= 9'd320) ? sx - 9'd320 : sx; m_pend_v = 1'b1;
    end
`endif
    m_vs = vs;
    addr_q.push_back(e);
    cycle();
  endtask

  task automatic check_reset_state();
    chk("rst rom_addr", 32'(rom_addr), 32'd0);
    chk("rst index_out", 32'(index_out), 32'd0);
    chk("rst active_out", 32'(active_out), 32'd0);
    chk("rst scroll_ack", 32'(scroll_ack), 32'd0);
    chk("rst hs_out", 32'(hs_out), 32'd1);
    chk("rst vs_out", 32'(vs_out), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    draw_x = '0; draw_y = '0; active_in = 1'b0; hs_in = 1'b1; vs_in = 1'b1; scroll_load = 1'b0;
    reset_n = 1'b0;
    #1;
    check_reset_state();
    addr_q.delete(); out_q.delete();
    m_cur = '0; m_pend = '0; m_pend_v = 1'b0; m_vs = 1'b1;
    #2;
    reset_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{10'd10,  10'd6,   1'b1, 1'b1, 1'b1, 17'd965};
    tbl[1] = '{10'd700, 10'd6,   1'b0, 1'b0, 1'b1, 17'd0};
    tbl[2] = '{10'd0,   10'd0,   1'b1, 1'b1, 1'b1, 17'd0};
    tbl[3] = '{10'd639, 10'd479, 1'b1, 1'b1, 1'b1, 17'd76799};
    tbl[4] = '{10'd1,   10'd1,   1'b1, 1'b1, 1'b0, 17'd0};
    tbl[5] = '{10'd2,   10'd2,   1'b1, 1'b1, 1'b0, 17'd321};
    tbl[6] = '{10'd320, 10'd100, 1'b1, 1'b0, 1'b1, 17'd16160};
    tbl[7] = '{10'd638, 10'd0,   1'b1, 1'b1, 1'b1, 17'd319};
    tbl[8] = '{10'd700, 10'd500, 1'b0, 1'b0, 1'b0, 17'd0};
    tbl[9] = '{10'd100, 10'd200, 1'b1, 1'b1, 1'b1, 17'd32050};

    #12;
    check_reset_state();
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 10; i++)
      apply(tbl[i].dx, tbl[i].dy, tbl[i].act, tbl[i].hs, tbl[i].vs, 1'b0, 9'd0, tbl[i].ea);
    apply(10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 9'd0, 17'd0);
    apply(10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 9'd0, 17'd0);

`ifdef BG_SCROLL_EN
    apply(10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 9'd100, addr_of(10'd0, 10'd0));
    apply(10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 9'd0, addr_of(10'd0, 10'd0));
    apply(10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 9'd0, 17'd100);
    apply(10'd500, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 9'd0, 17'd30);

    apply(10'd10, 10'd6, 1'b1, 1'b1, 1'b1, 1'b1, 9'd200, 17'd1065);
    for (int i = 0; i < 4; i++)
      apply(10'd10, 10'd6, 1'b1, 1'b1, 1'b1, 1'b0, 9'd0, 17'd1065);
    apply(10'd10, 10'd6, 1'b1, 1'b1, 1'b0, 1'b0, 9'd0, 17'd1065);
    apply(10'd10, 10'd6, 1'b1, 1'b1, 1'b1, 1'b0, 9'd0, 17'd1165);

    apply(10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 9'd40, addr_of(10'd0, 10'd0));
    apply(10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 9'd60, addr_of(10'd0, 10'd0));
    apply(10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b1, 9'd80, addr_of(10'd0, 10'd0));
    apply(10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 9'd0, 17'd60);
    apply(10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 9'd0, 17'd60);
    apply(10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 9'd0, 17'd80);

    apply(10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 9'd350, addr_of(10'd0, 10'd0));
    apply(10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 9'd0, addr_of(10'd0, 10'd0));
    apply(10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 9'd0, 17'd30);

    apply(10'd10, 10'd6, 1'b1, 1'b1, 1'b1, 1'b1, 9'd200, addr_of(10'd10, 10'd6));
    do_reset();
    apply(10'd10, 10'd6, 1'b1, 1'b1, 1'b1, 1'b0, 9'd0, 17'd965);
    apply(10'd10, 10'd6, 1'b1, 1'b1, 1'b0, 1'b0, 9'd0, 17'd965);
    apply(10'd10, 10'd6, 1'b1, 1'b1, 1'b1, 1'b0, 9'd0, 17'd965);
    apply(10'd10, 10'd6, 1'b1, 1'b1, 1'b1, 1'b0, 9'd0, 17'd965);
`else
    apply(10'd10, 10'd6, 1'b1, 1'b1, 1'b1, 1'b1, 9'd100, 17'd965);
    apply(10'd10, 10'd6, 1'b1, 1'b1, 1'b0, 1'b0, 9'd0, 17'd965);
    apply(10'd500, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 9'd0, 17'd250);
    apply(10'd10, 10'd6, 1'b1, 1'b1, 1'b1, 1'b0, 9'd0, 17'd965);
    do_reset();
    apply(10'd10, 10'd6, 1'b1, 1'b0, 1'b1, 1'b0, 9'd0, 17'd965);
    apply(10'd0, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0, 9'd0, 17'd0);
    apply(10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 9'd0, 17'd0);
`endif
    apply(10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 9'd0, 17'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
